// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the pushbutton debouncer:
//     - state_t   : FSM state encoding for debounce_pulse
//     - cnt_width : width of the stability / repeat counters, sized so the
//                   larger of the two cycle counts fits without wrapping
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_QUAL_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_QUAL_LO = 2'd3
    } state_t;

    function automatic int cnt_width(input int stable_cycles, input int repeat_cycles);
        int biggest;
        biggest = (stable_cycles > repeat_cycles) ? stable_cycles : repeat_cycles;
        return $clog2(biggest + 1);
    endfunction

endpackage

// File: rtl/debounce_pulse_if.sv
// debounce_pulse_if
//   Button-side signal bundle of the debouncer.
//   Signals:
//     btn_in     raw asynchronous button level (driven by the button side)
//     btn_level  debounced button level
//     t_pulse    one-cycle press pulse, feeds the counter t input
//     busy       high while a level change is being qualified
//   Modports:
//     master  button / consumer side: drives btn_in, observes the outputs
//     slave   the debouncer itself
interface debounce_pulse_if;

    logic btn_in;
    logic btn_level;
    logic t_pulse;
    logic busy;

    modport master (
        output btn_in,
        input  btn_level,
        input  t_pulse,
        input  busy
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output t_pulse,
        output busy
    );

endinterface

// File: rtl/debounce_pulse_sync_chain.sv
// sync_chain
//   Generic N-flop synchroniser for an asynchronous single-bit input, with a
//   synchronous active-high reset that clears every stage to 0. Reusable for
//   any async input of the design.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous, active-high reset
//     d    in   asynchronous input
//     q    out  synchronised output (last stage)
//   Parameters:
//     STAGES  number of flops, must be >= 2
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse
//   Conditions a raw, bouncy pushbutton into a clean debounced level and a
//   single-cycle press pulse that drives the toggle-enable of the downstream
//   4-bit synchronous counter. Shares clock and reset with that counter.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous, active-high reset
//     bus        slave modport of debounce_pulse_if
//                  btn_in (in), btn_level / t_pulse / busy (out)
//   Parameters:
//     SYNC_STAGES    synchroniser depth on btn_in (>= 2)
//     STABLE_CYCLES  consecutive equal samples needed to accept a new level (>= 2)
//     REPEAT_CYCLES  auto-repeat period while held (>= 2)
//   Build option:
//     DEBOUNCE_REPEAT_EN  when defined, a held button re-pulses t_pulse every
//                         REPEAT_CYCLES cycles after the initial press pulse;
//                         when undefined, exactly one pulse per press and no
//                         repeat logic exists.
//   All outputs are registered; btn_in reaches the FSM only through the
//   synchroniser.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_LOW     | debounced level is 0, synced input agrees
//   ST_QUAL_HI | synced input is 1, counting consecutive 1 samples
//   ST_HIGH    | debounced level is 1 (repeat counter runs when enabled)
//   ST_QUAL_LO | synced input is 0, counting consecutive 0 samples
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    debounce_pulse_if.slave  bus
);

    localparam int              CNT_W    = cnt_width(STABLE_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             t_pulse_q;
    logic             busy_q;
`ifdef DEBOUNCE_REPEAT_EN
    logic [CNT_W-1:0] rpt;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (s)
    );

    // busy is registered alongside the state: it is set on every transition
    // into a QUAL_* state and cleared on every transition out of one, so it
    // always equals (state is QUAL_*), i.e. cnt != 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOW;
            cnt       <= '0;
            level_q   <= 1'b0;
            t_pulse_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            rpt       <= '0;
`endif
        end else begin
            t_pulse_q <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (s) begin
                        state  <= ST_QUAL_HI;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end
                end

                ST_QUAL_HI: begin
                    if (!s) begin
                        state  <= ST_LOW;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_HIGH;
                        cnt       <= '0;
                        busy_q    <= 1'b0;
                        level_q   <= 1'b1;
                        t_pulse_q <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                        rpt       <= '0;
`endif
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_HIGH: begin
                    if (!s) begin
                        state  <= ST_QUAL_LO;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                        rpt    <= '0;
`endif
                    end
`ifdef DEBOUNCE_REPEAT_EN
                    // Period is measured from the press pulse: REPEAT_CYCLES
                    // held cycles after it, one more pulse, and so on.
                    else if (rpt == RPT_LAST) begin
                        rpt       <= '0;
                        t_pulse_q <= 1'b1;
                    end else begin
                        rpt <= rpt + CNT_ONE;
                    end
`endif
                end

                ST_QUAL_LO: begin
                    if (s) begin
                        // Bounce back to high: level never dropped, no new
                        // press pulse; repeat timing restarts from zero.
                        state  <= ST_HIGH;
                        cnt    <= '0;
                        busy_q <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
                        rpt    <= '0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_LOW;
                        cnt     <= '0;
                        busy_q  <= 1'b0;
                        level_q <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state  <= ST_LOW;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_level = level_q;
    assign bus.t_pulse   = t_pulse_q;
    assign bus.busy      = busy_q;

endmodule
